serv_issue_ctrl: RTL and testbench

//  Sequences fetch, decode and bit-serial execution for the SERV core.
//  - Owns the ibus request and pulses the decoder enable when an instruction word arrives.
//  - Runs the bit counter for the optional init pass and the final run pass.
//  - Owns the dbus handshake for load/store.
//  - Sits between the bus interfaces, serv_decode and the datapath (bufreg/alu/rf/ctrl).

---
 rtl/serv_pkg.sv | 16 +
 rtl/serv_issue_ctrl_if.sv | 24 ++
 rtl/serv_bit_counter.sv | 30 +++
 rtl/serv_issue_ctrl.sv | 83 ++++++++
 tb/tb_serv_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serv_pkg.sv
// Shared encodings for the SERV issue/sequencing logic.
// Counter width and FSM state codes live here.
package serv_pkg;

  localparam int CNT_W = 5;

  typedef logic [2:0] state_t;

  localparam state_t S_RST    = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_INIT   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_RUN    = 3'd5;

endpackage

// File: rtl/serv_issue_ctrl_if.sv
// Instruction and data bus cycle/ack handshakes.
// The issue controller is the master of both.
interface serv_issue_ctrl_if;

  logic ibus_cyc;
  logic ibus_ack;
  logic dbus_cyc;
  logic dbus_ack;

  modport master (
    output ibus_cyc,
    output dbus_cyc,
    input  ibus_ack,
    input  dbus_ack
  );

  modport slave (
    input  ibus_cyc,
    input  dbus_cyc,
    output ibus_ack,
    output dbus_ack
  );

endinterface

// File: rtl/serv_bit_counter.sv
// Bit index counter for one serial pass of 32/W cycles.
// Steps by W while enabled and wraps to zero on the last step.
module serv_bit_counter
  import serv_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(32 - W);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(W);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= o_done ? '0 : r_cnt + STEP;
  end

  assign o_cnt  = r_cnt;
  assign o_done = i_en && (r_cnt == LAST);

endmodule

// File: rtl/serv_issue_ctrl.sv
// Fetch/decode/execute sequencer for the bit-serial SERV core.
// Owns both bus handshakes and the pass counter.
module serv_issue_ctrl
  import serv_pkg::*;
#(
  parameter int W = 1
) (
  input  logic               clk,
  input  logic               i_rst,
  serv_issue_ctrl_if.master  io_bus,
  output logic               o_dec_en,
  input  logic               i_two_stage,
  input  logic               i_mem_op,
  input  logic               i_rd_op,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_cnt_en,
  output logic               o_cnt_done,
  output logic               o_init,
  output logic               o_rf_wen,
  output logic               o_pc_en
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_cnt;
  logic             w_done;
  logic             w_cnt_en;
  logic             w_ibus_cyc;
  logic             w_dbus_cyc;

  serv_bit_counter #(.W(W)) u_cnt (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_en   (w_cnt_en),
    .o_cnt  (w_cnt),
    .o_done (w_done)
  );

  always_ff @(posedge clk) begin
    if (i_rst)
      r_state <= S_RST;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  if (io_bus.ibus_ack) w_next = S_DECODE;
      S_DECODE: w_next = i_two_stage ? S_INIT : S_RUN;
      S_INIT:   if (w_done) w_next = i_mem_op ? S_MEM : S_RUN;
      S_MEM:    if (io_bus.dbus_ack) w_next = S_RUN;
      S_RUN:    if (w_done) w_next = S_FETCH;
      default:  w_next = S_RST;
    endcase
  end

  // Everything is masked by reset so outputs read zero while it is held.
  always_comb begin
    w_ibus_cyc = 1'b0;
    w_dbus_cyc = 1'b0;
    w_cnt_en   = 1'b0;
    o_init     = 1'b0;
    o_pc_en    = 1'b0;
    if (!i_rst) begin
      w_ibus_cyc = (r_state == S_FETCH);
      w_dbus_cyc = (r_state == S_MEM);
      w_cnt_en   = (r_state == S_INIT) || (r_state == S_RUN);
      o_init     = (r_state == S_INIT);
      o_pc_en    = (r_state == S_RUN);
    end
  end

  assign io_bus.ibus_cyc = w_ibus_cyc;
  assign io_bus.dbus_cyc = w_dbus_cyc;
  assign o_dec_en        = w_ibus_cyc && io_bus.ibus_ack;
  assign o_cnt_en        = w_cnt_en;
  assign o_cnt_done      = w_done;
  assign o_rf_wen        = o_pc_en && i_rd_op;
  assign o_cnt           = i_rst ? '0 : w_cnt;

endmodule

// File: tb/tb_serv_issue_ctrl.sv
// Scoreboard bench for serv_issue_ctrl, W=1 and W=4 instances.
// Random bus latencies, spurious acks, and mid-transaction resets.
module tb_serv_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sel;
  logic iack, dack;
  logic ts, mo, rd;

  serv_issue_ctrl_if if0 ();
  serv_issue_ctrl_if if1 ();

  logic rst0, rst1;
  assign rst0 = rst | sel;
  assign rst1 = rst | ~sel;
  assign if0.ibus_ack = iack & ~sel;
  assign if0.dbus_ack = dack & ~sel;
  assign if1.ibus_ack = iack & sel;
  assign if1.dbus_ack = dack & sel;

  logic       dec0, en0, done0, init0, rf0, pc0;
  logic       dec1, en1, done1, init1, rf1, pc1;
  logic [4:0] cnt0, cnt1;

  serv_issue_ctrl #(.W(1)) u0 (
    .clk(clk), .i_rst(rst0), .io_bus(if0),
    .o_dec_en(dec0), .i_two_stage(ts), .i_mem_op(mo), .i_rd_op(rd),
    .o_cnt(cnt0), .o_cnt_en(en0), .o_cnt_done(done0),
    .o_init(init0), .o_rf_wen(rf0), .o_pc_en(pc0)
  );

  serv_issue_ctrl #(.W(4)) u1 (
    .clk(clk), .i_rst(rst1), .io_bus(if1),
    .o_dec_en(dec1), .i_two_stage(ts), .i_mem_op(mo), .i_rd_op(rd),
    .o_cnt(cnt1), .o_cnt_en(en1), .o_cnt_done(done1),
    .o_init(init1), .o_rf_wen(rf1), .o_pc_en(pc1)
  );

  logic       m_icyc, m_dcyc, m_dec, m_en, m_done, m_init, m_rf, m_pc;
  logic [4:0] m_cnt;
  assign m_icyc = sel ? if1.ibus_cyc : if0.ibus_cyc;
  assign m_dcyc = sel ? if1.dbus_cyc : if0.dbus_cyc;
  assign m_dec  = sel ? dec1  : dec0;
  assign m_en   = sel ? en1   : en0;
  assign m_done = sel ? done1 : done0;
  assign m_init = sel ? init1 : init0;
  assign m_rf   = sel ? rf1   : rf0;
  assign m_pc   = sel ? pc1   : pc0;
  assign m_cnt  = sel ? cnt1  : cnt0;

  typedef struct {
    int init;
    int mem;
    int run;
    int rf;
  } rec_t;
  rec_t q[$];

  int npass = 0;
  int ntot  = 0;
  int ndone = 0;

  task automatic chk(string nm, int got, int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // ---------------- bus responder / stimulus ----------------
  bit bus_en, spur, toggle;
  int kind, dn_fix;
  bit ibusy, dbusy;
  int iwait, dwait, next_dn;

  task pick();
    int k, p;
    rec_t r;
    k = (kind == 0) ? $urandom_range(1, 4) : kind;
    case (k)
      1: {ts, mo, rd} = 3'b001;
      2: {ts, mo, rd} = 3'b111;
      3: {ts, mo, rd} = 3'b110;
      default: {ts, mo, rd} = 3'($urandom);
    endcase
    next_dn = (dn_fix != 0) ? dn_fix : $urandom_range(1, 6);
    p = sel ? 8 : 32;
    r.init = ts ? p : 0;
    r.mem  = (ts && mo) ? next_dn : 0;
    r.run  = p;
    r.rf   = rd ? p : 0;
    q.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    if (toggle) begin
      iack = ~iack;
      dack = 1'b0;
    end else if (!bus_en) begin
      iack = 1'b0; dack = 1'b0; ibusy = 0; dbusy = 0;
    end else begin
      if (m_icyc) begin
        if (!ibusy) begin ibusy = 1; iwait = $urandom_range(1, 4); end
        iwait--;
        iack = (iwait == 0);
        if (iack) begin ibusy = 0; pick(); end
        else {ts, mo, rd} = 3'($urandom);
      end else begin
        ibusy = 0;
        iack = spur && ($urandom_range(0, 2) == 0);
      end
      if (m_dcyc) begin
        if (!dbusy) begin dbusy = 1; dwait = next_dn; end
        dwait--;
        dack = (dwait == 0);
        if (dack) dbusy = 0;
      end else begin
        dbusy = 0;
        dack = spur && ($urandom_range(0, 2) == 0);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int  mcnt, ni, nm, nr, nf, nd, lat, glat;
  bit  latrun, wantf;

  always @(negedge clk) begin
    int w;
    rec_t r;
    w = sel ? 4 : 1;
    if (rst) begin
      mcnt = 0; ni = 0; nm = 0; nr = 0; nf = 0; nd = 0;
      glat = 0; latrun = 0; wantf = 0;
      q.delete();
    end else begin
      if (wantf) begin chk("fetch_b2b", m_icyc, 1); wantf = 0; end
      chk("strobe_legal",
          !(m_rf && !m_pc) && !(m_pc && !m_en) && !(m_pc && m_init) &&
          !(m_en && (m_icyc || m_dcyc)) && !(m_dec && !m_icyc), 1);
      if (m_dec) begin nd++; latrun = 1; lat = 0; end
      else if (latrun) begin
        lat++;
        if (m_en) begin latrun = 0; glat = lat; end
      end
      if (m_en) begin
        chk("cnt", m_cnt, mcnt);
        chk("cnt_done", m_done, (mcnt == 32 - w));
        mcnt = (mcnt + w) % 32;
      end
      if (m_en && m_init) ni++;
      if (m_dcyc) nm++;
      if (m_pc) nr++;
      if (m_rf) nf++;
      if (m_pc && m_done) begin
        if (q.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
          r = q.pop_front();
          chk("init_cycles", ni, r.init);
          chk("mem_cycles", nm, r.mem);
          chk("run_cycles", nr, r.run);
          chk("rf_wen_cycles", nf, r.rf);
          chk("dec_en_pulses", nd, 1);
          chk("ack_to_cnt_en", glat, 2);
        end
        ni = 0; nm = 0; nr = 0; nf = 0; nd = 0;
        ndone++;
        wantf = 1;
      end
    end
  end

  task automatic wait_done(int n);
    int tgt, c;
    tgt = ndone + n;
    c = 0;
    while (ndone < tgt && c < 3000) begin @(negedge clk); c++; end
    chk("progress", int'(ndone >= tgt), 1);
  endtask

  task automatic wait_dcyc();
    int c;
    c = 0;
    while (!m_dcyc && c < 3000) begin @(negedge clk); c++; end
    chk("reach_mem", m_dcyc, 1);
  endtask

  initial begin
    rst = 1; sel = 0; iack = 0; dack = 0;
    ts = 0; mo = 0; rd = 0;
    bus_en = 0; spur = 0; toggle = 0; kind = 0; dn_fix = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    @(negedge clk);
    chk("fetch_req", m_icyc, 1);

    // reset held during FETCH while ack toggles
    @(posedge clk);
    #2 rst = 1; toggle = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ibus_cyc", m_icyc, 0);
      chk("rst_dec_en", m_dec, 0);
      chk("rst_cnt", m_cnt, 0);
    end
    @(posedge clk);
    #2 rst = 0; toggle = 0;
    @(negedge clk);
    @(negedge clk);
    chk("fetch_after_rst", m_icyc, 1);

    bus_en = 1;
    kind = 1; wait_done(3);
    kind = 2; spur = 1; wait_done(3);
    kind = 3; wait_done(2);
    kind = 0; wait_done(10);

    // reset while waiting on the data bus
    kind = 2; dn_fix = 6; wait_done(1);
    wait_dcyc();
    @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("rst_mem_dbus_cyc", m_dcyc, 0);
    @(negedge clk);
    chk("rst_mem_dbus_cyc2", m_dcyc, 0);
    chk("rst_mem_cnt_en", m_en, 0);
    @(posedge clk);
    #2 rst = 0; dn_fix = 0;
    wait_done(3);

    // switch to the W=4 instance
    @(posedge clk);
    #2 rst = 1; sel = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    kind = 3; wait_done(2);
    kind = 1; wait_done(2);
    kind = 0; wait_done(10);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
